pc_gen: RTL

- Program-counter generator for the fetch stage; successor to the single-register PC.
- Adds parametrised width, reset vector and compressed-ISA support.
- Selects the next PC by fixed priority among sequential, branch/jump, mret and trap sources.
- Buffers a redirect that arrives while fetch is stalled, and flags misaligned branch/mret targets instead of following them.

---
 rtl/pc_gen_if.sv | 33 +++
 rtl/pc_gen.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator bus: redirect requests in, fetch PC and flags out.
interface pc_gen_if #(
  parameter int W = 64
);
  logic         i_clk_en;
  logic         i_stall;
  logic         i_is_compressed;
  logic         i_br_valid;
  logic [W-1:0] i_br_target;
  logic         i_mret_valid;
  logic [W-1:0] i_mret_epc;
  logic         i_trap_valid;
  logic [W-1:0] i_trap_vec;
  logic [W-1:0] o_pc;
  logic         o_pc_valid;
  logic         o_redirect;
  logic         o_misaligned;
  logic [W-1:0] o_misaligned_addr;

  modport master (
    output i_clk_en, i_stall, i_is_compressed,
    output i_br_valid, i_br_target, i_mret_valid, i_mret_epc,
    output i_trap_valid, i_trap_vec,
    input  o_pc, o_pc_valid, o_redirect, o_misaligned, o_misaligned_addr
  );

  modport slave (
    input  i_clk_en, i_stall, i_is_compressed,
    input  i_br_valid, i_br_target, i_mret_valid, i_mret_epc,
    input  i_trap_valid, i_trap_vec,
    output o_pc, o_pc_valid, o_redirect, o_misaligned, o_misaligned_addr
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: sequential stepping, prioritised redirects,
// stall-time redirect buffering and misaligned-target rejection.
//
// state | meaning
// BOOT  | first cycle after reset; PC = reset vector, not yet valid
// RUN   | normal fetch; PC steps or follows a redirect
// HOLD  | stalled with a redirect pending in the buffer
module pc_gen #(
  parameter logic [1:0]  XLEN         = 2'd2,
  parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_8000_0000,
  parameter bit          C_EXT        = 1'b1
) (
  input logic     i_clk,
  input logic     i_rst,
  pc_gen_if.slave bus
);
  localparam int W = 1 << (int'(XLEN) + 4);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
  typedef enum logic [1:0] {PRI_NONE, PRI_BR, PRI_MRET, PRI_TRAP} pri_t;

  state_t       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic         valid_q, valid_d;
  logic         redirect_q, redirect_d;
  logic         mis_q, mis_d;
  logic [W-1:0] mis_addr_q, mis_addr_d;
  logic [W-1:0] pend_tgt_q, pend_tgt_d;
  pri_t         pend_pri_q, pend_pri_d;

  pri_t         req_pri;
  logic [W-1:0] req_tgt;
  logic         req_mis;
  logic         req_ok;
  logic         req_higher;
  logic [W-1:0] seq_pc;
  logic [2:0]   step;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR[W-1:0];
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
      pend_tgt_q <= '0;
      pend_pri_q <= PRI_NONE;
    end else if (bus.i_clk_en) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      redirect_q <= redirect_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
      pend_tgt_q <= pend_tgt_d;
      pend_pri_q <= pend_pri_d;
    end
  end

  always_comb begin
    req_pri = PRI_NONE;
    req_tgt = '0;
    if (bus.i_trap_valid) begin
      req_pri = PRI_TRAP;
      req_tgt = bus.i_trap_vec & ~{{(W-2){1'b0}}, 2'b11};
    end else if (bus.i_mret_valid) begin
      req_pri = PRI_MRET;
      req_tgt = bus.i_mret_epc;
    end else if (bus.i_br_valid) begin
      req_pri = PRI_BR;
      req_tgt = bus.i_br_target;
    end

    // Trap vectors are forced aligned, so only mret/branch can be rejected.
    req_mis    = ((req_pri == PRI_MRET) || (req_pri == PRI_BR)) &&
                 (req_tgt[0] || (!C_EXT && req_tgt[1]));
    req_ok     = (req_pri != PRI_NONE) && !req_mis;
    req_higher = req_pri > pend_pri_q;

    step   = (C_EXT && bus.i_is_compressed) ? 3'd2 : 3'd4;
    seq_pc = pc_q + {{(W-3){1'b0}}, step};

    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    redirect_d = 1'b0;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
    pend_tgt_d = pend_tgt_q;
    pend_pri_d = pend_pri_q;

    case (state_q)
      BOOT: begin
        valid_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (req_mis) begin
          mis_d      = 1'b1;
          mis_addr_d = req_tgt;
        end
        if (!bus.i_stall) begin
          if (req_ok) begin
            pc_d       = req_tgt;
            redirect_d = 1'b1;
          end else begin
            pc_d = seq_pc;
          end
        end else if (req_ok) begin
          pend_tgt_d = req_tgt;
          pend_pri_d = req_pri;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // Only a strictly higher-priority request can disturb the pending one.
        if (req_higher && req_mis) begin
          mis_d      = 1'b1;
          mis_addr_d = req_tgt;
        end
        if (bus.i_stall) begin
          if (req_higher && req_ok) begin
            pend_tgt_d = req_tgt;
            pend_pri_d = req_pri;
          end
        end else begin
          pc_d       = (req_higher && req_ok) ? req_tgt : pend_tgt_q;
          redirect_d = 1'b1;
          pend_tgt_d = '0;
          pend_pri_d = PRI_NONE;
          state_d    = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign bus.o_pc              = pc_q;
  assign bus.o_pc_valid        = valid_q;
  assign bus.o_redirect        = redirect_q;
  assign bus.o_misaligned      = mis_q;
  assign bus.o_misaligned_addr = mis_addr_q;
endmodule
